// File: rtl/wb_pwm_multi.sv
// Wishbone multi-channel PWM: one prescaled timebase shared by N_CH compare channels,
// edge- or center-aligned, with period/duty/mode reloaded only at period boundaries.
module wb_pwm_multi #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [3:0]      wb_sel_i,
  output logic            wb_ack_o,
  output logic [N_CH-1:0] pwm_o,
  output logic            irq_o
);

  localparam logic [5:0] A_CTRL     = 6'h00;
  localparam logic [5:0] A_PERIOD   = 6'h01;
  localparam logic [5:0] A_PRESCALE = 6'h02;
  localparam logic [5:0] A_POL      = 6'h03;
  localparam logic [5:0] A_CHEN     = 6'h04;
  localparam logic [5:0] A_STATUS   = 6'h05;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q, en_d, center_q, center_d, irq_en_q, irq_en_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic             center_act_q, center_act_d;
  logic [PRE_W-1:0] prescale_q, prescale_d, pre_q, pre_d;
  logic [N_CH-1:0]  pol_q, pol_d, chen_q, chen_d, pwm_q, pwm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             down_q, down_d, pef_q, pef_d, irq_q;
  logic             tick, boundary, reload;

  logic             req, wr;
  logic [5:0]       idx;
  logic [31:0]      rdata;
  logic [CNT_W-1:0] duty_rd [32];
  logic             unused_bits;

  assign req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr  = req & wb_we_i;
  assign idx = wb_adr_i[7:2];
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  // While disabled the active copies track the shadows including a same-edge write,
  // so the enabling CTRL write can also select the mode it starts in.
  assign reload = ~en_q | boundary;

  always_comb begin
    en_d        = en_q;
    center_d    = center_q;
    irq_en_d    = irq_en_q;
    period_sh_d = period_sh_q;
    prescale_d  = prescale_q;
    pol_d       = pol_q;
    chen_d      = chen_q;
    if (wr) begin
      case (idx)
        A_CTRL: begin
          en_d     = wb_dat_i[0];
          center_d = wb_dat_i[1];
          irq_en_d = wb_dat_i[2];
        end
        A_PERIOD:   period_sh_d = wb_dat_i[CNT_W-1:0];
        A_PRESCALE: prescale_d  = wb_dat_i[PRE_W-1:0];
        A_POL:      pol_d       = wb_dat_i[N_CH-1:0];
        A_CHEN:     chen_d      = wb_dat_i[N_CH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    tick     = 1'b0;
    boundary = 1'b0;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    down_d   = down_q;
    if (!en_q) begin
      pre_d  = '0;
      cnt_d  = '0;
      down_d = 1'b0;
    end else begin
      // >= so that lowering PRESCALE below the running count wraps at once
      tick  = (pre_q >= prescale_q);
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        if (period_act_q == '0) begin
          cnt_d    = '0;
          down_d   = 1'b0;
          boundary = 1'b1;
        end else if (!center_act_q) begin
          down_d = 1'b0;
          if (cnt_q >= period_act_q) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (down_q) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d    = '0;
            down_d   = 1'b0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          down_d = (cnt_q >= period_act_q - 1'b1);
        end
      end
    end
  end

  always_comb begin
    period_act_d = reload ? period_sh_d : period_act_q;
    center_act_d = reload ? center_d : center_act_q;
    pef_d        = pef_q;
    if (wr && idx == A_STATUS && wb_dat_i[0]) pef_d = 1'b0;
    if (boundary) pef_d = 1'b1;
  end

  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_ch
    if (gi < N_CH) begin : g_used
      logic [CNT_W-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;

      always_comb begin
        duty_sh_d = duty_sh_q;
        if (wr && (idx == 6'(32 + gi))) duty_sh_d = wb_dat_i[CNT_W-1:0];
      end

      assign duty_act_d  = reload ? duty_sh_d : duty_act_q;
      assign pwm_d[gi]   = (en_q & chen_q[gi] & (cnt_q < duty_act_q)) ^ pol_q[gi];
      assign duty_rd[gi] = duty_sh_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          duty_sh_q  <= '0;
          duty_act_q <= '0;
        end else begin
          duty_sh_q  <= duty_sh_d;
          duty_act_q <= duty_act_d;
        end
      end
    end else begin : g_none
      assign duty_rd[gi] = '0;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      A_CTRL:     rdata = {29'b0, irq_en_q, center_q, en_q};
      A_PERIOD:   rdata = 32'(period_sh_q);
      A_PRESCALE: rdata = 32'(prescale_q);
      A_POL:      rdata = 32'(pol_q);
      A_CHEN:     rdata = 32'(chen_q);
      A_STATUS:   rdata = {16'(cnt_q), 15'b0, pef_q};
      default:    if (idx[5]) rdata = 32'(duty_rd[idx[4:0]]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      en_q         <= 1'b0;
      center_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      period_sh_q  <= '0;
      period_act_q <= '0;
      center_act_q <= 1'b0;
      prescale_q   <= '0;
      pre_q        <= '0;
      pol_q        <= '0;
      chen_q       <= '0;
      cnt_q        <= '0;
      down_q       <= 1'b0;
      pef_q        <= 1'b0;
      pwm_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      ack_q        <= req;
      dat_q        <= req ? rdata : '0;
      en_q         <= en_d;
      center_q     <= center_d;
      irq_en_q     <= irq_en_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      center_act_q <= center_act_d;
      prescale_q   <= prescale_d;
      pre_q        <= pre_d;
      pol_q        <= pol_d;
      chen_q       <= chen_d;
      cnt_q        <= cnt_d;
      down_q       <= down_d;
      pef_q        <= pef_d;
      pwm_q        <= pwm_d;
      irq_q        <= pef_q & irq_en_q;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign pwm_o    = pwm_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Self-checking bench for wb_pwm_multi: register table, arithmetic waveform model with
// randomized configurations, and hand sequences for reload, W1C and reset corner cases.
module tb_wb_pwm_multi;
  localparam int N_CH  = 8;
  localparam int CNT_W = 16;
  localparam int PRE_W = 8;

  localparam logic [31:0] R_CTRL   = 32'h00;
  localparam logic [31:0] R_PERIOD = 32'h04;
  localparam logic [31:0] R_PRE    = 32'h08;
  localparam logic [31:0] R_POL    = 32'h0C;
  localparam logic [31:0] R_CHEN   = 32'h10;
  localparam logic [31:0] R_STATUS = 32'h14;
  localparam logic [31:0] R_DUTY   = 32'h80;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     wb_adr_i = '0;
  logic [31:0]     wb_dat_i = '0;
  logic [31:0]     wb_dat_o;
  logic            wb_we_i = 1'b0;
  logic            wb_cyc_i = 1'b0;
  logic            wb_stb_i = 1'b0;
  logic [3:0]      wb_sel_i = 4'hF;
  logic            wb_ack_o;
  logic [N_CH-1:0] pwm_o;
  logic            irq_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .pwm_o(pwm_o), .irq_o(irq_o)
  );

  // configuration currently programmed, used by the reference model
  int         m_p, m_s;
  bit         m_ctr, m_ie;
  logic [7:0] m_pol, m_chen;
  int         m_duty [8];

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                     output logic [31:0] rdat);
    int n;
    @(negedge clk);
    chk("ack_idle", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 4);
    chk("ack", 32'(wb_ack_o), 32'd1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, adr, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, adr, 32'd0, r);
    chk(name, r, exp);
  endtask

  // counter value after n ticks from enable
  function automatic int cnt_at(int n, int p, bit ctr);
    int m;
    if (p == 0) return 0;
    if (!ctr) return n % (p + 1);
    m = n % (2 * p);
    return (m <= p) ? m : 2 * p - m;
  endfunction

  function automatic int ticks_per_period(int p, bit ctr);
    if (p == 0) return 1;
    return ctr ? 2 * p : p + 1;
  endfunction

  function automatic logic [7:0] pwm_model(int c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (m_chen[i] && (c < m_duty[i])) ^ m_pol[i];
    return r;
  endfunction

  task automatic setup();
    wr(R_CTRL, 32'd0);
    wr(R_STATUS, 32'd1);
    wr(R_PERIOD, 32'(m_p));
    wr(R_PRE, 32'(m_s));
    wr(R_POL, 32'(m_pol));
    wr(R_CHEN, 32'(m_chen));
    for (int i = 0; i < 8; i++) wr(R_DUTY + 32'(4 * i), 32'(m_duty[i]));
  endtask

  task automatic enable();
    wr(R_CTRL, {29'b0, m_ie, m_ctr, 1'b1});
  endtask

  task automatic run_cfg(input string tag, input int cycles);
    int c, lim;
    logic [15:0] c16;
    logic pef;
    setup();
    @(negedge clk);
    chk({tag, "_idle"}, 32'(pwm_o), 32'(m_pol));
    enable();
    lim = ticks_per_period(m_p, m_ctr) * (m_s + 1);
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      c = cnt_at((j - 1) / (m_s + 1), m_p, m_ctr);
      chk({tag, "_pwm"}, 32'(pwm_o), 32'(pwm_model(c)));
      chk({tag, "_irq"}, 32'(irq_o), 32'((m_ie && (j - 1 >= lim)) ? 1 : 0));
    end
    c   = cnt_at((cycles + 1) / (m_s + 1), m_p, m_ctr);
    c16 = 16'(c);
    pef = (cycles + 1 >= lim);
    rd_chk({tag, "_status"}, R_STATUS, {c16, 15'b0, pef});
  endtask

  task automatic count_high(input int bitn, input int ncyc, output int hi);
    hi = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (pwm_o[bitn]) hi++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, d, exp_bit;
    logic [31:0] r;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    rst = 1'b1;

    // register table: reads after reset, truncation, unmapped offsets
    tbl.push_back('{1'b0, R_CTRL,        32'h0,        32'h0});
    tbl.push_back('{1'b0, R_PERIOD,      32'h0,        32'h0});
    tbl.push_back('{1'b0, R_PRE,         32'h0,        32'h0});
    tbl.push_back('{1'b0, R_POL,         32'h0,        32'h0});
    tbl.push_back('{1'b0, R_CHEN,        32'h0,        32'h0});
    tbl.push_back('{1'b0, R_STATUS,      32'h0,        32'h0});
    tbl.push_back('{1'b0, 32'h80,        32'h0,        32'h0});
    tbl.push_back('{1'b0, 32'h9C,        32'h0,        32'h0});
    tbl.push_back('{1'b1, R_PERIOD,      32'hFFFF1234, 32'h0});
    tbl.push_back('{1'b0, R_PERIOD,      32'h0,        32'h1234});
    tbl.push_back('{1'b0, 32'h40000005,  32'h0,        32'h1234});
    tbl.push_back('{1'b1, R_PRE,         32'h000001FF, 32'h0});
    tbl.push_back('{1'b0, R_PRE,         32'h0,        32'hFF});
    tbl.push_back('{1'b1, R_POL,         32'hFFFFFABC, 32'h0});
    tbl.push_back('{1'b0, R_POL,         32'h0,        32'hBC});
    tbl.push_back('{1'b1, R_CHEN,        32'h12345671, 32'h0});
    tbl.push_back('{1'b0, R_CHEN,        32'h0,        32'h71});
    tbl.push_back('{1'b1, R_CTRL,        32'hFFFFFFFA, 32'h0});
    tbl.push_back('{1'b0, R_CTRL,        32'h0,        32'h2});
    tbl.push_back('{1'b1, 32'h9C,        32'hABCD5678, 32'h0});
    tbl.push_back('{1'b0, 32'h9C,        32'h0,        32'h5678});
    tbl.push_back('{1'b1, 32'hA0,        32'hFFFF,     32'h0});
    tbl.push_back('{1'b0, 32'hA0,        32'h0,        32'h0});
    tbl.push_back('{1'b1, 32'h18,        32'hFFFF,     32'h0});
    tbl.push_back('{1'b0, 32'h18,        32'h0,        32'h0});
    tbl.push_back('{1'b1, 32'h7C,        32'hFFFF,     32'h0});
    tbl.push_back('{1'b0, 32'h7C,        32'h0,        32'h0});
    tbl.push_back('{1'b0, R_STATUS,      32'h0,        32'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].adr, tbl[i].wdat);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].exp);
    end

    // edge mode, 10-clk period, duty 3, irq follows PEF
    m_p = 9; m_s = 0; m_ctr = 1'b0; m_ie = 1'b1; m_pol = 8'h00; m_chen = 8'h01;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    m_duty[0] = 3;
    run_cfg("t2", 30);
    count_high(0, 10, hi);
    chk("t2_width", 32'(hi), 32'd3);

    // mid-period duty change applies only after the next boundary
    setup();
    enable();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("t3_pre", 32'(pwm_o), 32'(((j - 1) % 10 < 3) ? 1 : 0));
    end
    wr(R_DUTY, 32'd7);
    for (int j = 7; j <= 30; j++) begin
      @(negedge clk);
      d = (j - 1 >= 10) ? 7 : 3;
      exp_bit = ((j - 1) % 10 < d) ? 1 : 0;
      chk("t3_reload", 32'(pwm_o), 32'(exp_bit));
    end
    wr(R_DUTY, 32'd0);
    repeat (25) @(negedge clk);
    count_high(0, 20, hi);
    chk("t3_duty0", 32'(hi), 32'd0);
    wr(R_DUTY, 32'd10);
    repeat (25) @(negedge clk);
    count_high(0, 20, hi);
    chk("t3_duty_full", 32'(hi), 32'd20);

    // center mode, 16-clk period, channel 1 high 6 clks
    m_p = 4; m_s = 1; m_ctr = 1'b1; m_ie = 1'b0; m_pol = 8'h00; m_chen = 8'h02;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    m_duty[1] = 2;
    run_cfg("t4", 40);
    count_high(1, 16, hi);
    chk("t4_width", 32'(hi), 32'd6);

    // polarity and channel enables; EN=0 drives the idle levels
    m_p = 5; m_s = 0; m_ctr = 1'b0; m_ie = 1'b0; m_pol = 8'h0F; m_chen = 8'h05;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    m_duty[0] = 2; m_duty[2] = 4;
    run_cfg("t5", 30);
    wr(R_CTRL, 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_idle", 32'(pwm_o), 32'h0F);

    // randomized configurations against the arithmetic model
    for (int t = 0; t < 6; t++) begin
      m_p = $urandom_range(0, 7);
      m_s = $urandom_range(0, 2);
      m_ctr = 1'($urandom_range(0, 1));
      m_ie = 1'($urandom_range(0, 1));
      m_pol = 8'($urandom);
      m_chen = 8'($urandom);
      for (int i = 0; i < 8; i++) m_duty[i] = $urandom_range(0, m_p + 1);
      $display("rnd%0d: P=%0d S=%0d center=%0d ie=%0d pol=%h chen=%h",
               t, m_p, m_s, m_ctr, m_ie, m_pol, m_chen);
      run_cfg($sformatf("rnd%0d", t), 60);
    end

    // W1C clear coinciding with a boundary: the set wins
    m_p = 9; m_s = 0; m_ctr = 1'b0; m_ie = 1'b1; m_pol = 8'h80; m_chen = 8'h01;
    for (int i = 0; i < 8; i++) m_duty[i] = 0;
    m_duty[0] = 3;
    setup();
    enable();
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk("t6_pwm", 32'(pwm_o), 32'(pwm_model(cnt_at(j - 1, 9, 1'b0))));
    end
    wr(R_STATUS, 32'd1);
    rd_chk("t6_pef_set_wins", R_STATUS, 32'h0001_0001);
    chk("t6_irq_set", 32'(irq_o), 32'd1);
    wr(R_STATUS, 32'd1);
    rd_chk("t6_pef_cleared", R_STATUS, 32'h0005_0000);
    chk("t6_irq_clr", 32'(irq_o), 32'd0);
    chk("t6_prereset", 32'(pwm_o), 32'h80);

    // reset mid-period with a bus cycle in flight
    @(negedge clk);
    rst = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = R_POL;
    @(negedge clk);
    chk("t6_rst_pwm", 32'(pwm_o), 32'd0);
    chk("t6_rst_ack", 32'(wb_ack_o), 32'd0);
    chk("t6_rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rd_chk("t6_rst_status", R_STATUS, 32'd0);
    rd_chk("t6_rst_ctrl", R_CTRL, 32'd0);
    rd_chk("t6_rst_pol", R_POL, 32'd0);
    rd_chk("t6_rst_period", R_PERIOD, 32'd0);
    bus(1'b0, R_DUTY, 32'd0, r);
    chk("t6_rst_duty0", r, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
